// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing stage: owns the PC, reads instruction memory,
// presents decoded fields for one EXEC cycle and follows jump/halt flags.
module fetch_sequencer #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  input  logic               jump_enable,
  input  logic               finaliza_execucao,
  output logic [7:0]         opcode,
  output logic [7:0]         reg1_sel,
  output logic [7:0]         reg2_sel,
  output logic [7:0]         imm,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic [CNT_W-1:0]   retired_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [INSTR_W-1:0]  instr_q;
  logic                req_q;
  logic                valid_q;
  logic                busy_q;
  logic                halted_q;
  logic [CNT_W-1:0]    retired_q;

  logic [ADDR_W-1:0]   pc_d;
  logic [CNT_W-1:0]    retired_d;

  // Post-EXEC PC (jump target or sequential, wrapping) and saturating retire count
  always_comb begin
    pc_d      = pc_q + ADDR_W'(1);
    retired_d = retired_q;
    if (jump_enable) begin
      pc_d = ADDR_W'(instr_q[7:0]);
    end
    if (retired_q != {CNT_W{1'b1}}) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            retired_q <= '0;
            req_q     <= 1'b1;
            busy_q    <= 1'b1;
            halted_q  <= 1'b0;
          end
        end
        S_FETCH: begin
          state_q <= S_WAIT;
          req_q   <= 1'b0;
        end
        S_WAIT: begin
          if (imem_valid) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Halt outranks jump; every executed word (including unknown opcodes) retires
          valid_q   <= 1'b0;
          retired_q <= retired_d;
          if (finaliza_execucao) begin
            state_q  <= S_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_FETCH;
            pc_q    <= pc_d;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          req_q    <= 1'b0;
          valid_q  <= 1'b0;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign opcode        = instr_q[31:24];
  assign reg1_sel      = instr_q[23:16];
  assign reg2_sel      = instr_q[15:8];
  assign imm           = instr_q[7:0];
  assign instr_valid   = valid_q;
  assign busy          = busy_q;
  assign halted        = halted_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: program memory with variable latency, a toy
// control unit decoding opcodes, and an instruction-level trace model.
module tb_fetch_sequencer;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 16;

  localparam logic [7:0] OP_JUMP = 8'h05;
  localparam logic [7:0] OP_BOTH = 8'h06;
  localparam logic [7:0] OP_HALT = 8'hFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_valid;
  logic               jump_enable;
  logic               finaliza_execucao;
  logic [7:0]         opcode, reg1_sel, reg2_sel, imm;
  logic               instr_valid;
  logic [ADDR_W-1:0]  pc;
  logic               busy, halted;
  logic [CNT_W-1:0]   retired_count;

  fetch_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .jump_enable(jump_enable), .finaliza_execucao(finaliza_execucao),
    .opcode(opcode), .reg1_sel(reg1_sel), .reg2_sel(reg2_sel), .imm(imm),
    .instr_valid(instr_valid), .pc(pc), .busy(busy), .halted(halted),
    .retired_count(retired_count)
  );

  // Combinational control unit: 05 jumps, FF halts, 06 asserts both
  assign jump_enable       = (opcode == OP_JUMP) || (opcode == OP_BOTH);
  assign finaliza_execucao = (opcode == OP_HALT) || (opcode == OP_BOTH);

  // Instruction memory: answers each request after 'lat' cycles
  logic [31:0] mem [256];
  int unsigned lat = 1;
  int unsigned cd = 0;
  logic [7:0]  raddr = '0;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        stray_valid = 1'b0;

  assign imem_valid = resp_valid | stray_valid;
  assign imem_rdata = stray_valid ? 32'hDEAD_BEEF : resp_data;

  always @(negedge clk) begin
    resp_valid = 1'b0;
    if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) begin
        resp_valid = 1'b1;
        resp_data  = mem[raddr];
      end
    end
    if (imem_req) begin
      cd    = lat;
      raddr = imem_addr;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Reference trace: fetch addresses and words in execution order
  logic [7:0]  exp_addr[$];
  logic [31:0] exp_word[$];
  bit          exp_halt;
  logic [7:0]  exp_pc;

  task automatic build_model(input int max_n);
    logic [7:0]  mpc;
    logic [31:0] w;
    exp_addr.delete();
    exp_word.delete();
    exp_halt = 1'b0;
    mpc = 8'd0;
    for (int i = 0; i < max_n; i++) begin
      w = mem[mpc];
      exp_addr.push_back(mpc);
      exp_word.push_back(w);
      if (w[31:24] == OP_HALT || w[31:24] == OP_BOTH) begin
        exp_halt = 1'b1;
        break;
      end else if (w[31:24] == OP_JUMP) mpc = w[7:0];
      else mpc = mpc + 8'd1;
    end
    exp_pc = mpc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic run_prog(input string name, input int max_n, input bit poke_wait);
    int n_req = 0;
    int n_exec = 0;
    int cyc = 0;
    int last_req = 0;
    int budget;
    int seen;
    bit poked = 1'b0;
    logic [31:0] w;
    build_model(max_n);
    budget = max_n * (int'(lat) + 2) + 10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (n_exec < exp_word.size() && cyc < budget) begin
      if (imem_req) begin
        if (n_req > 0) check({name, " req_spacing"}, 32'(cyc - last_req), 32'(lat + 2));
        if (n_req < exp_addr.size()) check({name, " imem_addr"}, 32'(imem_addr), 32'(exp_addr[n_req]));
        last_req = cyc;
        n_req++;
      end
      if (instr_valid) begin
        w = exp_word[n_exec];
        check({name, " opcode"}, 32'(opcode), 32'(w[31:24]));
        check({name, " reg1_sel"}, 32'(reg1_sel), 32'(w[23:16]));
        check({name, " reg2_sel"}, 32'(reg2_sel), 32'(w[15:8]));
        check({name, " imm"}, 32'(imm), 32'(w[7:0]));
        check({name, " exec_latency"}, 32'(cyc - last_req), 32'(lat + 1));
        check({name, " retired_in_exec"}, 32'(retired_count), 32'(n_exec));
        n_exec++;
      end
      start = 1'b0;
      if (poke_wait && !poked && busy && !imem_req && !instr_valid) begin
        start = 1'b1;
        poked = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({name, " instr_count"}, 32'(n_exec), 32'(exp_word.size()));
    if (exp_halt) begin
      check({name, " halted"}, 32'(halted), 32'd1);
      check({name, " busy_after_halt"}, 32'(busy), 32'd0);
      check({name, " retired_final"}, 32'(retired_count), 32'(exp_word.size()));
      check({name, " pc_final"}, 32'(pc), 32'(exp_pc));
      seen = 0;
      repeat (4) begin
        @(negedge clk);
        if (imem_req || instr_valid) seen++;
      end
      check({name, " quiet_in_halt"}, 32'(seen), 32'd0);
    end else begin
      check({name, " still_busy"}, 32'(busy), 32'd1);
    end
  endtask

  initial begin
    int seen;
    bit found;
    logic [31:0] w;
    logic [7:0]  op;
    int r;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    // Reset dominates start and a valid response
    rst = 1'b1;
    start = 1'b1;
    stray_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("reset fields", {opcode, reg1_sel, reg2_sel, imm}, 32'h0);
      check("reset ctrl", {28'h0, imem_req, instr_valid, busy, halted}, 32'h0);
      check("reset pc_addr", {16'h0, pc, imem_addr}, 32'h0);
      check("reset retired", 32'(retired_count), 32'h0);
    end
    rst = 1'b0;
    start = 1'b0;
    stray_valid = 1'b0;
    @(negedge clk);
    check("idle no_req", {30'h0, imem_req, busy}, 32'h0);

    // Sequential run ending in halt
    mem[0] = 32'h0001_0203;
    mem[1] = 32'h0902_0300;
    mem[2] = 32'hFF00_0000;
    lat = 1;
    run_prog("seq", 10, 1'b0);

    // Stray response while halted is dropped
    stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    @(negedge clk);
    check("stray opcode", 32'(opcode), 32'hFF);
    check("stray imm", 32'(imm), 32'h0);
    check("stray ctrl", {29'h0, instr_valid, halted, busy}, 32'h2);

    // Jump, then halt+jump priority
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]    = 32'h0500_0010;
    mem[8'h10] = 32'hFF00_0000;
    run_prog("jump", 10, 1'b0);
    mem[0] = 32'h0600_0000;
    run_prog("both", 10, 1'b0);

    // Wrap at the top of the address space with longer latency and a start poke in WAIT
    mem[0]    = 32'h0500_00FF;
    mem[8'hFF] = 32'h0100_0000;
    lat = 3;
    run_prog("wrap", 4, 1'b1);

    // Reset while waiting; the response lands afterwards and must be dropped
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h0500_0005;
    mem[5] = 32'h1122_3344;
    lat = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_req && imem_addr == 8'd5) found = 1'b1;
      else @(negedge clk);
    end
    check("rstmid found_fetch5", 32'(found), 32'd1);
    @(negedge clk);
    check("rstmid pc_in_wait", 32'(pc), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (instr_valid || imem_req) seen++;
    end
    check("rstmid no_activity", 32'(seen), 32'd0);
    check("rstmid fields", {opcode, reg1_sel, reg2_sel, imm}, 32'h0);
    check("rstmid state", {30'h0, halted, busy}, 32'h0);

    // Randomised programs and latencies
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 256; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 8) op = OP_HALT;
        else if (r < 11) op = OP_BOTH;
        else if (r < 30) op = OP_JUMP;
        else if (r < 60) op = 8'h00;
        else op = 8'($urandom_range(0, 255));
        w = {op, 8'($urandom), 8'($urandom), 8'($urandom)};
        mem[i] = w;
      end
      lat = $urandom_range(1, 4);
      if (busy) do_reset();
      run_prog("rand", 25, k[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction fetch and sequencing stage that sits directly upstream of the control unit. It owns the program counter and issues reads to instruction memory. It splits the returned 32-bit word into opcode and operand fields, then presents them for exactly one execute cycle. It consumes the control unit's jump_enable and finaliza_execucao flags to select the next PC or to halt.

Parameters:
ADDR_W, 8, program counter and instruction-memory address width
INSTR_W, 32, instruction word width (fixed layout below, must be 32)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  single-cycle pulse, begins execution at PC 0
imem_req  output  1  read strobe to instruction memory, one cycle per fetch
imem_addr  output  ADDR_W  read address, equals pc while imem_req=1
imem_rdata  input  INSTR_W  returned instruction word
imem_valid  input  1  imem_rdata valid; memory responds >=1 cycle after imem_req
jump_enable  input  1  from control unit, evaluated during EXEC
finaliza_execucao  input  1  from control unit, halt request evaluated during EXEC
opcode  output  8  instr[31:24], feeds control unit
reg1_sel  output  8  instr[23:16], destination/first register index
reg2_sel  output  8  instr[15:8], second register index
imm  output  8  instr[7:0], immediate / jump target / memory address
instr_valid  output  1  high only in EXEC; datapath writes are qualified by it
pc  output  ADDR_W  current program counter
busy  output  1  high in FETCH, WAIT and EXEC
halted  output  1  high in HALT
retired_count  output  CNT_W  instructions completed since start

Behaviour:
- Reset values: state=IDLE, pc=0, instr register=0 (so opcode/reg1_sel/reg2_sel/imm=0), imem_req=0, imem_addr=0, instr_valid=0, busy=0, halted=0, retired_count=0.
- Reset is evaluated before all other conditions and wins over every other input in the same cycle.
- IDLE: start=1 -> FETCH, pc=0, retired_count=0.
- FETCH (1 cycle): imem_req=1, imem_addr=pc; always -> WAIT.
- WAIT: imem_req=0. imem_valid=1 -> latch imem_rdata into instr register, then -> EXEC. Otherwise stay; there is no timeout.
- EXEC (1 cycle): instr_valid=1; field outputs are driven from the instr register. The control unit is combinational, so its flags are sampled in this same cycle.
  - finaliza_execucao=1 -> HALT; pc unchanged; retired_count+1.
  - else jump_enable=1 -> pc=imm[ADDR_W-1:0], zero-extended if ADDR_W>8, truncated if ADDR_W<8; -> FETCH; retired_count+1.
  - else pc=pc+1 modulo 2^ADDR_W; -> FETCH; retired_count+1.
- Halt has priority over jump when both flags are high.
- HALT: no imem_req; halted=1; outputs hold. start=1 -> FETCH with pc=0 and retired_count=0. Only rst returns the block to IDLE.
- Throughput: 3 cycles per instruction at memory latency 1 (FETCH, WAIT, EXEC); each extra latency cycle adds 1.
- Field outputs hold their last value outside EXEC; consumers must qualify with instr_valid.
- imem_valid is ignored in every state except WAIT; stray or late responses are dropped.
- start is ignored in FETCH, WAIT and EXEC.
- pc wraps from 2^ADDR_W-1 to 0 without a flag.
- retired_count saturates at all-ones; it does not wrap.
- rst during WAIT -> IDLE next edge. A response arriving after reset is ignored and must not update the instr register.
- Unknown opcodes are sequenced as no-ops: pc+1, counted as retired.

Test Plan:
- Reset: rst=1 for 2 cycles with start=1 and imem_valid=1 -> all outputs at reset values, no imem_req.
- Sequential run: start; memory latency 1 returns 0x0001_0203, 0x0902_0300, 0xFF00_0000 at addresses 0,1,2 -> imem_addr 0,1,2 on req cycles 3 apart; EXEC opcodes 0x00, 0x09, 0xFF; halted=1; retired_count=3; no further req.
- Jump: word 0x0500_0010 at address 0 with control asserting jump_enable -> next imem_addr=0x10. Also force jump_enable and finaliza_execucao together -> HALT, pc stays 0.
- Wrap/latency: ADDR_W=4, pc preset by jump to 15, memory latency 3 with no jump -> EXEC 4 cycles after req, next imem_addr=0; instr_valid high exactly 1 cycle per instruction.
- Reset mid-operation: rst during WAIT at pc=5, imem_valid pulses the cycle after -> state IDLE, opcode=0, instr_valid never asserted.
- Restart and stray data: imem_valid pulse in HALT is ignored. start in HALT -> imem_addr=0, retired_count=0. start pulse during WAIT changes nothing.
